// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for the UART TX message arbiter
//
// Purpose: state encoding, CR/LF terminator bytes and default sizing
// parameters used by uart_tx_arbiter and its testbench.
// Ports: none (package).
package uart_pkg;

  localparam int DEF_N_REQ       = 2;
  localparam int DEF_TIMEOUT_CYC = 4096;

  localparam logic [7:0] CR_BYTE = 8'h0D;
  localparam logic [7:0] LF_BYTE = 8'h0A;

  // ST_CR and ST_LF are only reachable when UART_ARB_CRLF_EN is defined.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_CR   = 2'd2,
    ST_LF   = 2'd3
  } arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick
//
// Purpose: choose the first asserted request starting one past the last
// granted index, wrapping modulo N_REQ.
// Ports:
//   req_i       in  N_REQ          request vector
//   last_idx_i  in  $clog2(N_REQ)  index granted most recently
//   gnt_o       out N_REQ          one-hot winner, zero when no request
//   idx_o       out $clog2(N_REQ)  winner index (0 when no request)
module rr_arbiter #(
  parameter int N_REQ = 2
) (
  input  logic [N_REQ-1:0]         req_i,
  input  logic [$clog2(N_REQ)-1:0] last_idx_i,
  output logic [N_REQ-1:0]         gnt_o,
  output logic [$clog2(N_REQ)-1:0] idx_o
);

  localparam int IW = $clog2(N_REQ);

  // One extra bit so last_idx + k (< 2*N_REQ) never overflows before the wrap.
  logic [IW:0] cand;
  logic        found;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = {1'b0, last_idx_i} + (IW+1)'(k);
      if (cand >= (IW+1)'(N_REQ)) begin
        cand = cand - (IW+1)'(N_REQ);
      end
      if (!found && req_i[cand[IW-1:0]]) begin
        found = 1'b1;
        idx_o = cand[IW-1:0];
      end
    end
    if (found) begin
      gnt_o[idx_o] = 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin message arbiter feeding a UART TX byte FIFO
//
// Purpose: grants one requester at a time for a whole message, passes its
// bytes straight to the TX FIFO, and revokes the grant after TIMEOUT_CYC
// stall cycles. Optional feature macro: UART_ARB_CRLF_EN appends 0x0D 0x0A
// after every completed message.
// Ports:
//   clk, rst       in   clock, synchronous active-high reset
//   req_valid      in   N_REQ    per-requester byte valid
//   req_data       in   8*N_REQ  per-requester byte, requester i at [8i+7:8i]
//   req_last       in   N_REQ    last byte of message
//   req_ready      out  N_REQ    byte accepted this cycle
//   i_full         in   1        TX FIFO full
//   o_wr, o_byte   out  1, 8     TX FIFO write strobe and byte
//   o_grant        out  N_REQ    one-hot owner, zero when idle
//   o_busy         out  1        not idle
//   o_abort        out  1        one-cycle pulse on timeout revoke
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int N_REQ       = DEF_N_REQ,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [8*N_REQ-1:0]   req_data,
  input  logic [N_REQ-1:0]     req_last,
  output logic [N_REQ-1:0]     req_ready,
  input  logic                 i_full,
  output logic                 o_wr,
  output logic [7:0]           o_byte,
  output logic [N_REQ-1:0]     o_grant,
  output logic                 o_busy,
  output logic                 o_abort
);

  localparam int IW = $clog2(N_REQ);
  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  arb_state_e       state_q, state_d;
  logic [IW-1:0]    last_idx_q, last_idx_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [CW-1:0]    stall_q, stall_d;
  logic             abort_q, abort_d;

  logic [N_REQ-1:0] rr_gnt;
  logic [IW-1:0]    rr_idx;

  logic             own_valid;
  logic             own_last;
  logic [7:0]       own_data;

  rr_arbiter #(.N_REQ(N_REQ)) u_rr (
    .req_i      (req_valid),
    .last_idx_i (last_idx_q),
    .gnt_o      (rr_gnt),
    .idx_o      (rr_idx)
  );

  // While busy, last_idx_q is the current owner.
  always_comb begin
    own_valid = 1'b0;
    own_last  = 1'b0;
    own_data  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (last_idx_q == IW'(i)) begin
        own_valid = req_valid[i];
        own_last  = req_last[i];
        own_data  = req_data[8*i +: 8];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    last_idx_d = last_idx_q;
    grant_d    = grant_q;
    stall_d    = stall_q;
    abort_d    = 1'b0;
    o_wr       = 1'b0;
    o_byte     = '0;
    req_ready  = '0;
    case (state_q)
      ST_IDLE: begin
        if (|req_valid) begin
          state_d    = ST_XFER;
          grant_d    = rr_gnt;
          last_idx_d = rr_idx;
          stall_d    = '0;
        end
      end
      ST_XFER: begin
        o_byte    = own_data;
        o_wr      = own_valid & ~i_full;
        req_ready = grant_q & {N_REQ{o_wr}};
        if (o_wr) begin
          stall_d = '0;
          if (own_last) begin
`ifdef UART_ARB_CRLF_EN
            state_d = ST_CR;
`else
            state_d = ST_IDLE;
            grant_d = '0;
`endif
          end
        end else if (!own_valid && !i_full) begin
          // A full FIFO is downstream back-pressure, not a requester stall.
          if (stall_q == CW'(TIMEOUT_CYC - 1)) begin
            state_d = ST_IDLE;
            grant_d = '0;
            stall_d = '0;
            abort_d = 1'b1;
          end else begin
            stall_d = stall_q + 1'b1;
          end
        end
      end
`ifdef UART_ARB_CRLF_EN
      ST_CR: begin
        o_byte = CR_BYTE;
        o_wr   = ~i_full;
        if (!i_full) begin
          state_d = ST_LF;
        end
      end
      ST_LF: begin
        o_byte = LF_BYTE;
        o_wr   = ~i_full;
        if (!i_full) begin
          state_d = ST_IDLE;
          grant_d = '0;
        end
      end
`endif
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      last_idx_q <= IW'(N_REQ - 1);
      grant_q    <= '0;
      stall_q    <= '0;
      abort_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_idx_q <= last_idx_d;
      grant_q    <= grant_d;
      stall_q    <= stall_d;
      abort_q    <= abort_d;
    end
  end

  assign o_grant = grant_q;
  assign o_busy  = (state_q != ST_IDLE);
  assign o_abort = abort_q;

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter N_REQ, default 2, is the number of message requesters (legal range 2..8).
REQ-002 Parameter TIMEOUT_CYC, default 4096, is the stall cycles allowed mid-message before the grant is revoked.
REQ-003 clk  in  1  clock, all logic on posedge.
REQ-004 rst  in  1  reset; synchronous, active-high, clock clk.
REQ-005 req_valid  in  N_REQ  per-requester byte valid.
REQ-006 req_data  in  8*N_REQ  per-requester byte; requester i uses bits [8i+7:8i].
REQ-007 req_last  in  N_REQ  per-requester last-byte-of-message flag, qualified by req_valid.
REQ-008 req_ready  out  N_REQ  per-requester byte accepted this cycle.
REQ-009 i_full  in  1  downstream TX byte FIFO full.
REQ-010 o_wr  out  1  write strobe to the TX byte FIFO.
REQ-011 o_byte  out  8  byte to the TX byte FIFO, valid when o_wr=1.
REQ-012 o_grant  out  N_REQ  one-hot current owner; all-zero when idle.
REQ-013 o_busy  out  1  high in any state other than IDLE.
REQ-014 o_abort  out  1  one-cycle pulse when a grant is revoked by timeout.

Function
REQ-015 States: IDLE, XFER, CR, LF; CR and LF exist only with UART_ARB_CRLF_EN.
REQ-016 IDLE: if any req_valid=1, register the round-robin winner into o_grant and enter XFER next cycle; no byte moves in IDLE.
REQ-017 Round-robin: search starts at (last granted index + 1) mod N_REQ; the winner becomes the last granted index.
REQ-018 XFER, owner g: o_wr = req_valid[g] & ~i_full, o_byte = req_data[g], req_ready[g] = o_wr; all other req_ready = 0.
REQ-019 o_wr and req_ready are combinational from registered state; no buffering; zero-cycle latency from accepted byte to FIFO write.
REQ-020 Grant is held for the whole message; other requesters are not serviced until the owner's req_last byte is accepted.
REQ-021 When the owner's byte with req_last=1 is accepted: go to CR if CRLF is enabled, else to IDLE; o_grant clears on that state entry.
REQ-022 A requester may re-win in the cycle after its message ends only if no other requester has req_valid=1.
REQ-023 Stall counter: counts XFER cycles with req_valid[g]=0; cycles with i_full=1 are not counted; cleared on each accepted byte and on grant.
REQ-024 When the stall counter reaches TIMEOUT_CYC: pulse o_abort, clear o_grant, go to IDLE; no CR/LF is appended.
REQ-025 Single-byte messages (first byte has req_last=1) are legal and complete in one XFER transfer.

Reset
REQ-026 On rst: state=IDLE, o_grant=0, o_wr=0, req_ready=0, o_abort=0, o_busy=0, stall counter=0, last granted index=N_REQ-1 (requester 0 has priority first).
REQ-027 rst mid-message drops the message with no CR/LF; bytes already written stay in the FIFO.

Configuration
REQ-028 Macro UART_ARB_CRLF_EN defined: after each completed (non-aborted) message, write 0x0D in state CR, then 0x0A in state LF, each waiting while i_full=1, then go to IDLE.
REQ-029 In CR and LF, req_ready = 0 for all requesters and o_grant still shows the finishing owner.
REQ-030 Macro UART_ARB_CRLF_EN undefined: CR and LF states are absent; last byte goes directly to IDLE.

Structure
REQ-031 Shared package uart_pkg holds the state enum, the CR/LF byte constants, and the default N_REQ/TIMEOUT_CYC values.
REQ-032 One sub-module, rr_arbiter: combinational round-robin pick (inputs request vector and last index; outputs one-hot grant and index).

Verification
REQ-033 Req0 sends 3 bytes 0x41,0x42,0x43 (last on 0x43), i_full=0 -> grant in cycle 1, o_wr for 3 consecutive cycles, bytes in order; with CRLF, then 0x0D,0x0A; then IDLE.
REQ-034 Req0 and req1 both valid from reset -> req0 is served first, then req1; after that, with both valid again, req0 is served next.
REQ-035 Req1 mid-message with i_full held high for 10000 cycles -> no o_abort, no o_wr; transfer resumes when i_full falls.
REQ-036 Req0 drops req_valid mid-message for TIMEOUT_CYC cycles -> o_abort pulses once, o_grant=0, pending req1 is granted next.
REQ-037 rst asserted in XFER after 2 of 5 bytes -> next cycle all outputs are 0 and IDLE; no CR/LF is written.
REQ-038 Single-byte message 0x55 with last=1 and i_full toggling every cycle -> exactly one o_wr with 0x55 (plus CR/LF if enabled), no duplicates.
